// File: rtl/circle_points_generator_if.sv
// circle_points_generator_if: start/centre/radius request plus ready/valid point stream.
interface circle_points_generator_if #(
    parameter int WIDTH = 32,
    parameter int COUNT_WIDTH = 16
);
    logic _start;
    logic signed [WIDTH-1:0] cx;
    logic signed [WIDTH-1:0] cy;
    logic signed [WIDTH-1:0] radius;
    logic _ready;
    logic signed [WIDTH-1:0] _out0;
    logic signed [WIDTH-1:0] _out1;
    logic _valid;
    logic [COUNT_WIDTH-1:0] _count;
    logic _done;
    modport master (
        output _start, cx, cy, radius, _ready,
        input _out0, _out1, _valid, _count, _done
    );
    modport slave (
        input _start, cx, cy, radius, _ready,
        output _out0, _out1, _valid, _count, _done
    );
endinterface

// File: rtl/circle_points_generator.sv
// circle_points_generator: midpoint-circle point streamer, 8 octant points per iteration.
module circle_points_generator #(
    parameter int WIDTH = 32,
    parameter int COUNT_WIDTH = 16
) (
    input logic _clock,
    input logic _reset,
    circle_points_generator_if.slave bus
);
    localparam int IW = WIDTH + 3;
    localparam logic signed [IW-1:0] ONE = IW'(1);
    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;
    state_t state, state_n;
    logic signed [IW-1:0] x, y, d, x_n, y_n, d_n, y_inc, x_dec, d_lt, d_ge, r_ext;
    logic signed [WIDTH-1:0] cxr, cyr, cxr_n, cyr_n, xs, ys, dx, dy;
    logic [2:0] k, k_n;
    logic [COUNT_WIDTH-1:0] count, count_n;
    logic fire;
    assign r_ext = IW'(bus.radius);
    assign xs = x[WIDTH-1:0];
    assign ys = y[WIDTH-1:0];
    // Octant k selects which of +-x/+-y feeds each axis; sums wrap at WIDTH bits.
    assign dx = (k == 3'd0 || k == 3'd7) ? xs : (k == 3'd3 || k == 3'd4) ? -xs : (k == 3'd1 || k == 3'd6) ? ys : -ys;
    assign dy = (k == 3'd0 || k == 3'd3) ? ys : (k == 3'd4 || k == 3'd7) ? -ys : (k == 3'd1 || k == 3'd2) ? xs : -xs;
    assign bus._valid = state == EMIT;
    assign bus._done = state == DONE;
    assign bus._out0 = (state == EMIT) ? cxr + dx : '0;
    assign bus._out1 = (state == EMIT) ? cyr + dy : '0;
    assign bus._count = count;
    assign fire = bus._valid && bus._ready;
    assign y_inc = y + ONE;
    assign x_dec = x - ONE;
    assign d_lt = d + (y_inc <<< 1) + ONE;
    assign d_ge = d + ((y_inc - x_dec) <<< 1) + ONE;
    always_comb begin
        state_n = state;
        x_n = x;
        y_n = y;
        d_n = d;
        k_n = k;
        cxr_n = cxr;
        cyr_n = cyr;
        count_n = (fire && count != '1) ? count + COUNT_WIDTH'(1) : count;
        if (bus._start) begin
            cxr_n = bus.cx;
            cyr_n = bus.cy;
            x_n = r_ext;
            y_n = '0;
            d_n = ONE - r_ext;
            k_n = '0;
            count_n = '0;
            state_n = bus.radius[WIDTH-1] ? DONE : EMIT;
        end else if (fire) begin
            k_n = k + 3'd1;
            if (k == 3'd7) begin
                y_n = y_inc;
                x_n = d[IW-1] ? x : x_dec;
                d_n = d[IW-1] ? d_lt : d_ge;
                state_n = (y_inc > x_n) ? DONE : EMIT;
            end
        end
    end
    always_ff @(posedge _clock) begin
        if (_reset) begin
            state <= IDLE;
            x <= '0;
            y <= '0;
            d <= '0;
            k <= '0;
            cxr <= '0;
            cyr <= '0;
            count <= '0;
        end else begin
            state <= state_n;
            x <= x_n;
            y <= y_n;
            d <= d_n;
            k <= k_n;
            cxr <= cxr_n;
            cyr <= cyr_n;
            count <= count_n;
        end
    end
endmodule

// File: tb/tb_circle_points_generator.sv
// tb_circle_points_generator: directed checks of the circle point streamer.
module tb_circle_points_generator;
    logic _clock = 1'b0;
    logic _reset = 1'b1;
    int total = 0;
    int bad = 0;
    always #5 _clock = ~_clock;

    circle_points_generator_if #(.WIDTH(32), .COUNT_WIDTH(16)) bus ();
    circle_points_generator_if #(.WIDTH(8), .COUNT_WIDTH(16)) bus8 ();

    circle_points_generator #(.WIDTH(32), .COUNT_WIDTH(16)) dut (
        ._clock(_clock), ._reset(_reset), .bus(bus)
    );
    circle_points_generator #(.WIDTH(8), .COUNT_WIDTH(16)) dut8 (
        ._clock(_clock), ._reset(_reset), .bus(bus8)
    );

    int r3x[24] = '{3, 0, 0, -3, -3, 0, 0, 3, 3, 1, -1, -3, -3, -1, 1, 3, 2, 2, -2, -2, -2, -2, 2, 2};
    int r3y[24] = '{0, 3, 3, 0, 0, -3, -3, 0, 1, 3, 3, 1, -1, -3, -3, -1, 2, 2, 2, 2, -2, -2, -2, -2};
    int r2x[16] = '{2, 0, 0, -2, -2, 0, 0, 2, 2, 1, -1, -2, -2, -1, 1, 2};
    int r2y[16] = '{0, 2, 2, 0, 0, -2, -2, 0, 1, 2, 2, 1, -1, -2, -2, -1};
    int w8x[8] = '{-128, 127, 127, 126, 126, 127, 127, -128};
    int w8y[8] = '{0, 1, 1, 0, 0, -1, -1, 0};

    task automatic step();
        @(posedge _clock);
        #1;
    endtask

    task automatic kick(input int x0, input int y0, input int r);
        bus._start = 1'b1; bus.cx = x0; bus.cy = y0; bus.radius = r;
        step();
        bus._start = 1'b0;
    endtask

    task automatic test_reset();
        _reset = 1'b1;
        step(); step();
        total++; if (bus._valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus._valid); end
        total++; if (bus._done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus._done); end
        total++; if (bus._count !== 16'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", bus._count); end
        total++; if (bus._out0 !== 32'sd0 || bus._out1 !== 32'sd0) begin bad++; $display("FAIL reset_out: got (%0d,%0d) want (0,0)", bus._out0, bus._out1); end
        _reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        bus._ready = 1'b1;
        kick(10, 20, 0);
        for (int i = 0; i < 8; i++) begin
            total++; if (bus._valid !== 1'b1 || bus._out0 !== 32'sd10 || bus._out1 !== 32'sd20) begin bad++; $display("FAIL single_pt[%0d]: got v=%b (%0d,%0d) want v=1 (10,20)", i, bus._valid, bus._out0, bus._out1); end
            total++; if (bus._count !== 16'(i)) begin bad++; $display("FAIL single_count[%0d]: got %0d want %0d", i, bus._count, i); end
            step();
        end
        total++; if (bus._valid !== 1'b0 || bus._done !== 1'b1) begin bad++; $display("FAIL single_end: got v=%b done=%b want v=0 done=1", bus._valid, bus._done); end
        total++; if (bus._count !== 16'd8) begin bad++; $display("FAIL single_total: got %0d want 8", bus._count); end
        step();
        total++; if (bus._done !== 1'b1) begin bad++; $display("FAIL single_done_hold: got %b want 1", bus._done); end
    endtask

    task automatic test_full();
        bus._ready = 1'b1;
        kick(0, 0, 3);
        total++; if (bus._done !== 1'b0) begin bad++; $display("FAIL full_done_clear: got %b want 0", bus._done); end
        for (int i = 0; i < 24; i++) begin
            total++; if (bus._valid !== 1'b1 || bus._out0 !== r3x[i] || bus._out1 !== r3y[i]) begin bad++; $display("FAIL full_pt[%0d]: got v=%b (%0d,%0d) want (%0d,%0d)", i, bus._valid, bus._out0, bus._out1, r3x[i], r3y[i]); end
            step();
        end
        total++; if (bus._valid !== 1'b0 || bus._done !== 1'b1 || bus._count !== 16'd24) begin bad++; $display("FAIL full_end: got v=%b done=%b count=%0d want 0 1 24", bus._valid, bus._done, bus._count); end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        logic held = 1'b0;
        logic signed [31:0] p0 = '0, p1 = '0;
        bus._ready = 1'b0;
        kick(100, -50, 2);
        for (int c = 0; c < 300 && idx < 16; c++) begin
            total++; if (bus._valid !== 1'b1 || bus._out0 !== r2x[idx] + 100 || bus._out1 !== r2y[idx] - 50) begin bad++; $display("FAIL bp_pt[%0d]: got v=%b (%0d,%0d) want (%0d,%0d)", idx, bus._valid, bus._out0, bus._out1, r2x[idx] + 100, r2y[idx] - 50); end
            if (held) begin
                total++; if (bus._out0 !== p0 || bus._out1 !== p1) begin bad++; $display("FAIL bp_stall[%0d]: got (%0d,%0d) want (%0d,%0d)", idx, bus._out0, bus._out1, p0, p1); end
            end
            total++; if (bus._count !== 16'(idx)) begin bad++; $display("FAIL bp_count[%0d]: got %0d want %0d", idx, bus._count, idx); end
            bus._ready = 1'($urandom_range(0, 1));
            held = !bus._ready;
            p0 = bus._out0; p1 = bus._out1;
            if (bus._ready) idx++;
            step();
        end
        total++; if (idx != 16) begin bad++; $display("FAIL bp_timeout: got %0d transfers want 16", idx); end
        total++; if (bus._valid !== 1'b0 || bus._done !== 1'b1 || bus._count !== 16'd16) begin bad++; $display("FAIL bp_end: got v=%b done=%b count=%0d want 0 1 16", bus._valid, bus._done, bus._count); end
        bus._ready = 1'b1;
    endtask

    task automatic test_restart();
        bus._ready = 1'b1;
        kick(0, 0, 3);
        for (int i = 0; i < 5; i++) step();
        total++; if (bus._out0 !== r3x[5] || bus._out1 !== r3y[5] || bus._count !== 16'd5) begin bad++; $display("FAIL restart_pre: got (%0d,%0d) count=%0d want (%0d,%0d) 5", bus._out0, bus._out1, bus._count, r3x[5], r3y[5]); end
        kick(7, 7, 0);
        total++; if (bus._valid !== 1'b1 || bus._out0 !== 32'sd7 || bus._out1 !== 32'sd7) begin bad++; $display("FAIL restart_first: got v=%b (%0d,%0d) want (7,7)", bus._valid, bus._out0, bus._out1); end
        total++; if (bus._count !== 16'd0 || bus._done !== 1'b0) begin bad++; $display("FAIL restart_clear: got count=%0d done=%b want 0 0", bus._count, bus._done); end
        for (int i = 0; i < 8; i++) begin
            total++; if (bus._valid !== 1'b1 || bus._out0 !== 32'sd7 || bus._out1 !== 32'sd7 || bus._count !== 16'(i)) begin bad++; $display("FAIL restart_pt[%0d]: got v=%b (%0d,%0d) count=%0d want (7,7) %0d", i, bus._valid, bus._out0, bus._out1, bus._count, i); end
            step();
        end
        total++; if (bus._valid !== 1'b0 || bus._done !== 1'b1 || bus._count !== 16'd8) begin bad++; $display("FAIL restart_end: got v=%b done=%b count=%0d want 0 1 8", bus._valid, bus._done, bus._count); end
    endtask

    task automatic test_reset_midrun();
        bus._ready = 1'b1;
        kick(0, 0, 3);
        step(); step(); step();
        total++; if (bus._count !== 16'd3) begin bad++; $display("FAIL midrst_pre: got %0d want 3", bus._count); end
        _reset = 1'b1;
        step();
        _reset = 1'b0;
        total++; if (bus._valid !== 1'b0 || bus._done !== 1'b0 || bus._count !== 16'd0) begin bad++; $display("FAIL midrst_state: got v=%b done=%b count=%0d want 0 0 0", bus._valid, bus._done, bus._count); end
        step(); step(); step();
        total++; if (bus._valid !== 1'b0 || bus._done !== 1'b0) begin bad++; $display("FAIL midrst_idle: got v=%b done=%b want 0 0", bus._valid, bus._done); end
    endtask

    task automatic test_negative();
        bus._ready = 1'b1;
        kick(5, 5, -1);
        total++; if (bus._done !== 1'b1 || bus._valid !== 1'b0) begin bad++; $display("FAIL neg_done: got done=%b v=%b want 1 0", bus._done, bus._valid); end
        step(); step();
        total++; if (bus._count !== 16'd0 || bus._valid !== 1'b0 || bus._done !== 1'b1) begin bad++; $display("FAIL neg_hold: got count=%0d v=%b done=%b want 0 0 1", bus._count, bus._valid, bus._done); end
    endtask

    task automatic test_wrap();
        bus8._ready = 1'b1;
        bus8._start = 1'b1; bus8.cx = 8'sd127; bus8.cy = 8'sd0; bus8.radius = 8'sd1;
        step();
        bus8._start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total++; if (bus8._valid !== 1'b1 || int'(bus8._out0) !== w8x[i] || int'(bus8._out1) !== w8y[i]) begin bad++; $display("FAIL wrap_pt[%0d]: got v=%b (%0d,%0d) want (%0d,%0d)", i, bus8._valid, bus8._out0, bus8._out1, w8x[i], w8y[i]); end
            step();
        end
        total++; if (bus8._valid !== 1'b0 || bus8._done !== 1'b1 || bus8._count !== 16'd8) begin bad++; $display("FAIL wrap_end: got v=%b done=%b count=%0d want 0 1 8", bus8._valid, bus8._done, bus8._count); end
    endtask

    initial begin
        bus._start = 1'b0; bus.cx = '0; bus.cy = '0; bus.radius = '0; bus._ready = 1'b0;
        bus8._start = 1'b0; bus8.cx = '0; bus8.cy = '0; bus8.radius = '0; bus8._ready = 1'b0;
        #1;
        test_reset();
        test_single();
        test_full();
        test_backpressure();
        test_restart();
        test_reset_midrun();
        test_negative();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
